// File: rtl/y86_stage_sequencer.sv
// y86_stage_sequencer: multi-cycle FETCH..PCUPD stage controller with ready handshakes,
// status latch, wait timeout and saturating cycle/retired-instruction counters.
module y86_stage_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             dmem_error_i,
    output logic             f_en_o,
    output logic             d_en_o,
    output logic             e_en_o,
    output logic             m_en_o,
    output logic             wb_we_o,
    output logic             pc_we_o,
    output logic [2:0]       stat_o,
    output logic             running_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT} state_t;
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;
    state_t      state, state_nx;
    logic [3:0]  icode, icode_nx;
    logic [2:0]  stat_nx;
    logic [31:0] wait_cnt;
    logic        retire, expired, mem_op;
    // Expiry fires on the TIMEOUT-th consecutive not-ready cycle; ready is tested first so it wins.
    assign expired = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));
    assign mem_op  = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    assign f_en_o    = state == FETCH;
    assign d_en_o    = state == DECODE;
    assign e_en_o    = state == EXECUTE;
    assign m_en_o    = state == MEMORY;
    assign wb_we_o   = state == WRITEBACK;
    assign pc_we_o   = state == PCUPD;
    assign running_o = state != IDLE && state != HALT;
    always_comb begin
        state_nx = state;
        stat_nx  = stat_o;
        icode_nx = icode;
        retire   = 1'b0;
        case (state)
            IDLE: state_nx = start_i ? FETCH : IDLE;
            FETCH: begin
                if (imem_ready_i) begin
                    if (imem_error_i || !instr_valid_i || icode_i == 4'h0) begin
                        state_nx = HALT;
                        stat_nx  = imem_error_i ? ADR : !instr_valid_i ? INS : HLT;
                        retire   = !imem_error_i && instr_valid_i;
                    end else begin
                        state_nx = DECODE;
                        icode_nx = icode_i;
                    end
                end else if (expired) begin
                    state_nx = HALT;
                    stat_nx  = ADR;
                end
            end
            DECODE:  state_nx = EXECUTE;
            EXECUTE: state_nx = mem_op ? MEMORY : WRITEBACK;
            MEMORY: begin
                if (dmem_ready_i) begin
                    state_nx = dmem_error_i ? HALT : WRITEBACK;
                    stat_nx  = dmem_error_i ? ADR : stat_o;
                end else if (expired) begin
                    state_nx = HALT;
                    stat_nx  = ADR;
                end
            end
            WRITEBACK: state_nx = PCUPD;
            PCUPD: begin
                state_nx = FETCH;
                retire   = 1'b1;
            end
            default: state_nx = state;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            stat_o      <= AOK;
            icode       <= 4'h0;
            wait_cnt    <= '0;
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            state       <= state_nx;
            stat_o      <= stat_nx;
            icode       <= icode_nx;
            wait_cnt    <= (state_nx == state && (state == FETCH || state == MEMORY)) ? wait_cnt + 32'd1 : '0;
            cycle_cnt_o <= (running_o && cycle_cnt_o != '1) ? cycle_cnt_o + CNT_W'(1) : cycle_cnt_o;
            instr_cnt_o <= (retire && instr_cnt_o != '1) ? instr_cnt_o + CNT_W'(1) : instr_cnt_o;
        end
    end
endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb_y86_stage_sequencer: drives instruction programs with random memory waits and compares
// against a per-instruction latency/status model; also a CNT_W=4 instance for saturation.
module tb_y86_stage_sequencer;
    localparam int TO = 16;
    logic clk = 0, rst = 1, start = 0, instr_valid = 0, imem_error = 0, imem_ready = 0;
    logic dmem_ready = 0, dmem_error = 0;
    logic [3:0] icode = 4'h0;
    logic f_en, d_en, e_en, m_en, wb_we, pc_we, running;
    logic [2:0] stat;
    logic [31:0] cyc, ins;
    logic s_f, s_d, s_e, s_m, s_wb, s_pc, s_run;
    logic [2:0] s_stat;
    logic [3:0] s_cyc, s_ins;
    int tests = 0, fails = 0;
    int n_f = 0, n_d = 0, n_e = 0, n_m = 0, n_wb = 0, n_pc = 0;
    int b_f, b_m, b_wb, b_pc, b_d;
    int np;
    logic [3:0] p_ic[16];
    int p_iw[16], p_dw[16];
    bit p_val[16], p_ierr[16], p_derr[16];
    int e_cyc, e_ins, e_f, e_m, e_wb, e_pc;
    logic [2:0] e_stat;

    y86_stage_sequencer #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode), .instr_valid_i(instr_valid),
        .imem_error_i(imem_error), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .dmem_error_i(dmem_error), .f_en_o(f_en), .d_en_o(d_en), .e_en_o(e_en), .m_en_o(m_en),
        .wb_we_o(wb_we), .pc_we_o(pc_we), .stat_o(stat), .running_o(running),
        .cycle_cnt_o(cyc), .instr_cnt_o(ins));

    y86_stage_sequencer #(.CNT_W(4), .TIMEOUT(TO)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode), .instr_valid_i(instr_valid),
        .imem_error_i(imem_error), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .dmem_error_i(dmem_error), .f_en_o(s_f), .d_en_o(s_d), .e_en_o(s_e), .m_en_o(s_m),
        .wb_we_o(s_wb), .pc_we_o(s_pc), .stat_o(s_stat), .running_o(s_run),
        .cycle_cnt_o(s_cyc), .instr_cnt_o(s_ins));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_f += int'(f_en); n_d += int'(d_en); n_e += int'(e_en);
        n_m += int'(m_en); n_wb += int'(wb_we); n_pc += int'(pc_we);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; start = 0; imem_ready = 0; dmem_ready = 0; dmem_error = 0;
        imem_error = 0; instr_valid = 0; icode = 4'h0;
        step();
        rst = 0;
        step();
        b_f = n_f; b_d = n_d; b_m = n_m; b_wb = n_wb; b_pc = n_pc;
    endtask

    function automatic bit is_mem(logic [3:0] c);
        return c inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic set_ins(int i, logic [3:0] ic, int iw, int dw, bit dr, bit v, bit ie);
        p_ic[i] = ic; p_iw[i] = iw; p_dw[i] = dw; p_derr[i] = dr; p_val[i] = v; p_ierr[i] = ie;
    endtask

    // Instruction-level model: each instruction costs its fetch dwell, D, E, optional memory dwell, W, P.
    task automatic model();
        bit done = 0;
        e_cyc = 0; e_ins = 0; e_f = 0; e_m = 0; e_wb = 0; e_pc = 0; e_stat = 3'd1;
        for (int i = 0; i < np && !done; i++) begin
            if (p_iw[i] >= TO) begin
                e_cyc += TO; e_f += TO; e_stat = 3'd3; done = 1;
            end else begin
                e_cyc += p_iw[i] + 1; e_f += p_iw[i] + 1;
                if (p_ierr[i]) begin e_stat = 3'd3; done = 1; end
                else if (!p_val[i]) begin e_stat = 3'd4; done = 1; end
                else if (p_ic[i] == 4'h0) begin e_stat = 3'd2; e_ins++; done = 1; end
                else begin
                    e_cyc += 2;
                    if (is_mem(p_ic[i])) begin
                        if (p_dw[i] >= TO) begin e_cyc += TO; e_m += TO; e_stat = 3'd3; done = 1; end
                        else begin
                            e_cyc += p_dw[i] + 1; e_m += p_dw[i] + 1;
                            if (p_derr[i]) begin e_stat = 3'd3; done = 1; end
                        end
                    end
                    if (!done) begin e_cyc += 2; e_wb++; e_pc++; e_ins++; end
                end
            end
        end
    endtask

    task automatic drive_prog();
        int t;
        start = 1; step(); start = 0;
        for (int i = 0; i < np; i++) begin
            t = 0;
            while (!f_en && t < 100) begin step(); t++; end
            if (t >= 100) begin tests++; fails++; $display("FAIL fetch_wait instr %0d f_en stuck 0, want 1", i); return; end
            imem_ready = 0;
            for (int k = 0; k < p_iw[i] && k < TO; k++) step();
            if (p_iw[i] >= TO) return;
            imem_ready = 1; icode = p_ic[i]; instr_valid = p_val[i]; imem_error = p_ierr[i];
            step();
            imem_ready = 0; imem_error = 0;
            if (p_ierr[i] || !p_val[i] || p_ic[i] == 4'h0) return;
            if (is_mem(p_ic[i])) begin
                t = 0;
                while (!m_en && t < 20) begin step(); t++; end
                if (t >= 20) begin tests++; fails++; $display("FAIL mem_wait instr %0d m_en stuck 0, want 1", i); return; end
                dmem_ready = 0;
                for (int k = 0; k < p_dw[i] && k < TO; k++) step();
                if (p_dw[i] >= TO) return;
                dmem_ready = 1; dmem_error = p_derr[i];
                step();
                dmem_ready = 0; dmem_error = 0;
                if (p_derr[i]) return;
            end
        end
    endtask

    task automatic run_prog();
        do_reset();
        model();
        drive_prog();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        if (stat !== 3'd1) begin fails++; $display("FAIL reset_stat got %0d want 1", stat); end
        tests++;
        if ({f_en, d_en, e_en, m_en, wb_we, pc_we, running} !== 7'd0) begin fails++; $display("FAIL reset_en got %b want 0", {f_en, d_en, e_en, m_en, wb_we, pc_we, running}); end
        tests++;
        if (cyc !== 0 || ins !== 0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cyc, ins); end
        tests++;
    endtask

    task automatic test_opq();
        do_reset();
        icode = 4'h6; instr_valid = 1; imem_ready = 1;
        start = 1; step(); start = 0;
        for (int c = 1; c <= 15; c++) begin
            if (pc_we !== (c % 5 == 0)) begin fails++; $display("FAIL opq_pc_we cycle %0d got %b want %b", c, pc_we, c % 5 == 0); end
            tests++;
            if (wb_we !== (c % 5 == 4)) begin fails++; $display("FAIL opq_wb_we cycle %0d got %b want %b", c, wb_we, c % 5 == 4); end
            tests++;
            step();
        end
        imem_ready = 0;
        if (cyc !== 32'd15 || ins !== 32'd3 || stat !== 3'd1) begin fails++; $display("FAIL opq_counts got cyc=%0d ins=%0d stat=%0d want 15/3/1", cyc, ins, stat); end
        tests++;
    endtask

    task automatic test_mem_wait();
        np = 2;
        set_ins(0, 4'h5, 0, 3, 0, 1, 0);
        set_ins(1, 4'h0, 0, 0, 0, 1, 0);
        run_prog();
        if (n_m - b_m !== 4) begin fails++; $display("FAIL mem_m_en got %0d want 4", n_m - b_m); end
        tests++;
        if (n_wb - b_wb !== 1) begin fails++; $display("FAIL mem_wb got %0d want 1", n_wb - b_wb); end
        tests++;
        if (cyc !== 32'(e_cyc) || e_cyc !== 10) begin fails++; $display("FAIL mem_cycles got %0d want %0d", cyc, e_cyc); end
        tests++;
    endtask

    task automatic test_halt();
        int tot;
        np = 3;
        set_ins(0, 4'h1, 0, 0, 0, 1, 0);
        set_ins(1, 4'h1, 1, 0, 0, 1, 0);
        set_ins(2, 4'h0, 0, 0, 0, 1, 0);
        run_prog();
        if (stat !== 3'd2 || ins !== 32'd3 || running !== 1'b0) begin fails++; $display("FAIL halt_state got stat=%0d ins=%0d run=%b want 2/3/0", stat, ins, running); end
        tests++;
        tot = n_f + n_d + n_e + n_m + n_wb + n_pc;
        for (int k = 0; k < 6; k++) begin start = ~start; step(); end
        start = 0;
        if (n_f + n_d + n_e + n_m + n_wb + n_pc !== tot || cyc !== 32'(e_cyc)) begin fails++; $display("FAIL halt_absorb got en=%0d cyc=%0d want %0d/%0d", n_f + n_d + n_e + n_m + n_wb + n_pc, cyc, tot, e_cyc); end
        tests++;
    endtask

    task automatic test_ins();
        np = 1;
        set_ins(0, 4'h6, 0, 0, 0, 0, 0);
        run_prog();
        if (stat !== 3'd4) begin fails++; $display("FAIL ins_stat got %0d want 4", stat); end
        tests++;
        if (n_wb - b_wb !== 0 || n_pc - b_pc !== 0) begin fails++; $display("FAIL ins_strobes got wb=%0d pc=%0d want 0/0", n_wb - b_wb, n_pc - b_pc); end
        tests++;
        set_ins(0, 4'h6, 0, 0, 0, 0, 1);
        run_prog();
        if (stat !== 3'd3) begin fails++; $display("FAIL adr_stat got %0d want 3", stat); end
        tests++;
    endtask

    task automatic test_timeout();
        np = 1;
        set_ins(0, 4'h1, TO, 0, 0, 1, 0);
        run_prog();
        if (stat !== 3'd3 || n_f - b_f !== TO || cyc !== 32'(TO)) begin fails++; $display("FAIL timeout got stat=%0d f=%0d cyc=%0d want 3/%0d/%0d", stat, n_f - b_f, cyc, TO, TO); end
        tests++;
        np = 2;
        set_ins(0, 4'h1, TO - 1, 0, 0, 1, 0);
        set_ins(1, 4'h0, 0, 0, 0, 1, 0);
        run_prog();
        if (stat !== 3'd2 || n_d - b_d !== 1 || cyc !== 32'(e_cyc)) begin fails++; $display("FAIL late_ready got stat=%0d d=%0d cyc=%0d want 2/1/%0d", stat, n_d - b_d, cyc, e_cyc); end
        tests++;
        np = 1;
        set_ins(0, 4'h9, 0, TO, 0, 1, 0);
        run_prog();
        if (stat !== 3'd3 || n_m - b_m !== TO || n_wb - b_wb !== 0) begin fails++; $display("FAIL dmem_timeout got stat=%0d m=%0d wb=%0d want 3/%0d/0", stat, n_m - b_m, n_wb - b_wb, TO); end
        tests++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            np = $urandom_range(2, 8);
            for (int i = 0; i < np; i++)
                set_ins(i, 4'($urandom_range(1, 11)), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 9) == 0, 1, 0);
            set_ins(np - 1, 4'h0, $urandom_range(0, 3), 0, 0, 1, 0);
            run_prog();
            if (cyc !== 32'(e_cyc)) begin fails++; $display("FAIL rand%0d cycle_cnt got %0d want %0d", r, cyc, e_cyc); end
            tests++;
            if (ins !== 32'(e_ins)) begin fails++; $display("FAIL rand%0d instr_cnt got %0d want %0d", r, ins, e_ins); end
            tests++;
            if (stat !== e_stat) begin fails++; $display("FAIL rand%0d stat got %0d want %0d", r, stat, e_stat); end
            tests++;
            if (n_f - b_f !== e_f || n_m - b_m !== e_m) begin fails++; $display("FAIL rand%0d dwell got f=%0d m=%0d want %0d/%0d", r, n_f - b_f, n_m - b_m, e_f, e_m); end
            tests++;
            if (n_wb - b_wb !== e_wb || n_pc - b_pc !== e_pc) begin fails++; $display("FAIL rand%0d strobes got wb=%0d pc=%0d want %0d/%0d", r, n_wb - b_wb, n_pc - b_pc, e_wb, e_pc); end
            tests++;
        end
    endtask

    task automatic test_async_reset();
        int t = 0;
        do_reset();
        start = 1; step(); start = 0;
        icode = 4'h5; instr_valid = 1; imem_ready = 1; step(); imem_ready = 0;
        dmem_ready = 0;
        while (!m_en && t < 10) begin step(); t++; end
        step();
        if (m_en !== 1'b1) begin fails++; $display("FAIL async_pre m_en got %b want 1", m_en); end
        tests++;
        #2 rst = 1;
        #1;
        if ({f_en, d_en, e_en, m_en, wb_we, pc_we, running} !== 7'd0 || stat !== 3'd1 || cyc !== 0 || ins !== 0) begin
            fails++; $display("FAIL async_reset got en=%b stat=%0d cyc=%0d want 0/1/0", {f_en, d_en, e_en, m_en, wb_we, pc_we, running}, stat, cyc);
        end
        tests++;
        step();
        rst = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        icode = 4'h1; instr_valid = 1; imem_ready = 1;
        start = 1; step(); start = 0;
        repeat (100) step();
        imem_ready = 0;
        if (s_ins !== 4'd15 || s_cyc !== 4'd15) begin fails++; $display("FAIL sat_cnt got ins=%0d cyc=%0d want 15/15", s_ins, s_cyc); end
        tests++;
        if (ins !== 32'd20 || cyc !== 32'd100) begin fails++; $display("FAIL wide_cnt got ins=%0d cyc=%0d want 20/100", ins, cyc); end
        tests++;
    endtask

    initial begin
        test_reset();
        test_opq();
        test_mem_wait();
        test_halt();
        test_ins();
        test_timeout();
        test_random();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
